// File: rtl/i8008_mem_if_pkg.sv
// Types shared by the 8008 memory/IO bridge: core T-states, bus cycle types
// and the bridge FSM encoding.
package i8008_mem_if_pkg;

    typedef enum logic [2:0] {
        T1      = 3'd0,
        T1I     = 3'd1,
        T2      = 3'd2,
        T_WAIT  = 3'd3,
        T3      = 3'd4,
        STOPPED = 3'd5,
        T4      = 3'd6,
        T5      = 3'd7
    } state_t;

    // Cycle type is carried in D_out[7:6] during T2.
    typedef enum logic [1:0] {
        PCI = 2'b00,
        PCC = 2'b01,
        PCR = 2'b10,
        PCW = 2'b11
    } cyc_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        RD_REQ  = 3'd2,
        HOLD    = 3'd3,
        WR_WAIT = 3'd4,
        WR_BUSY = 3'd5
    } fsm_t;

    function automatic logic is_t1(input state_t s);
        return (s == T1) || (s == T1I);
    endfunction

endpackage

// File: rtl/i8008_mem_if.sv
// Bridge between the 8008 core's multiplexed T-state bus and a simple
// request/ack memory port plus a strobed I/O port.
module i8008_mem_if
    import i8008_mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  state_t                state,
    input  logic                  Sync,
    input  logic [7:0]            D_out,
    output logic [7:0]            D_in,
    output logic                  READY,
    input  logic [7:0]            int_instr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic                  io_strobe,
    output logic [4:0]            io_port,
    output logic [7:0]            io_wdata,
    input  logic [7:0]            io_rdata
);

    fsm_t                  fsm_q, fsm_d;
    logic [7:0]            addr_lo_q, addr_lo_d;
    logic [5:0]            addr_hi_q, addr_hi_d;
    cyc_t                  cyc_q, cyc_d;
    logic                  int_cyc_q, int_cyc_d;
    logic                  pend_t1_q, pend_t1_d;
    logic                  pend_t2_q, pend_t2_d;
    logic [7:0]            d_in_q, d_in_d;
    logic                  ready_q, ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  io_strobe_q, io_strobe_d;
    logic [4:0]            io_port_q, io_port_d;
    logic [7:0]            io_wdata_q, io_wdata_d;

    logic                  dispatch_s;
    logic [5:0]            disp_hi_s;
    cyc_t                  disp_cyc_s;
    logic                  unused_sync_s;

    // Sync is observed only by external monitors.
    assign unused_sync_s = Sync;

    // Next-state and output computation for the bridge FSM.
    always_comb begin
        fsm_d       = fsm_q;
        addr_lo_d   = addr_lo_q;
        addr_hi_d   = addr_hi_q;
        cyc_d       = cyc_q;
        int_cyc_d   = int_cyc_q;
        pend_t1_d   = pend_t1_q;
        pend_t2_d   = pend_t2_q;
        d_in_d      = d_in_q;
        ready_d     = ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        io_strobe_d = 1'b0;
        io_port_d   = io_port_q;
        io_wdata_d  = io_wdata_q;
        dispatch_s  = 1'b0;
        disp_hi_s   = D_out[5:0];
        disp_cyc_s  = cyc_t'(D_out[7:6]);

        if (is_t1(state)) begin
            addr_lo_d = D_out;
            int_cyc_d = (state == T1I);
        end else if (state == T2) begin
            addr_hi_d = D_out[5:0];
            cyc_d     = cyc_t'(D_out[7:6]);
        end else begin
            addr_lo_d = addr_lo_q;
        end

        case (fsm_q)
            IDLE: begin
                if (is_t1(state)) fsm_d = ADDR;
                else              fsm_d = IDLE;
            end
            ADDR: begin
                if (state == T2) dispatch_s = 1'b1;
                else             fsm_d = ADDR;
            end
            RD_REQ: begin
                if (mem_ack) begin
                    fsm_d     = HOLD;
                    mem_req_d = 1'b0;
                    d_in_d    = mem_rdata;
                    ready_d   = 1'b1;
                end else begin
                    fsm_d = RD_REQ;
                end
            end
            HOLD: begin
                if (state == T3) begin
                    fsm_d   = IDLE;
                    ready_d = 1'b0;
                end else begin
                    fsm_d = HOLD;
                end
            end
            WR_WAIT: begin
                if (state == T3) begin
                    fsm_d       = WR_BUSY;
                    mem_wdata_d = D_out;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    ready_d     = 1'b0;
                end else begin
                    fsm_d = WR_WAIT;
                end
            end
            WR_BUSY: begin
                // The core may start its next cycle before the write completes;
                // remember T1/T2 and replay them once the ack arrives.
                if (is_t1(state)) pend_t1_d = 1'b1;
                else              pend_t1_d = pend_t1_q;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    pend_t1_d = 1'b0;
                    pend_t2_d = 1'b0;
                    if (state == T2) begin
                        dispatch_s = 1'b1;
                    end else if (pend_t2_q) begin
                        dispatch_s = 1'b1;
                        disp_hi_s  = addr_hi_q;
                        disp_cyc_s = cyc_q;
                    end else if (pend_t1_q || is_t1(state)) begin
                        fsm_d = ADDR;
                    end else begin
                        fsm_d = IDLE;
                    end
                end else if (state == T2) begin
                    pend_t2_d = 1'b1;
                end else begin
                    pend_t2_d = pend_t2_q;
                end
            end
            default: fsm_d = IDLE;
        endcase

        if (dispatch_s) begin
            if (int_cyc_q) begin
                fsm_d   = HOLD;
                d_in_d  = int_instr;
                ready_d = 1'b1;
            end else begin
                case (disp_cyc_s)
                    PCC: begin
                        fsm_d       = HOLD;
                        io_strobe_d = 1'b1;
                        io_port_d   = disp_hi_s[5:1];
                        io_wdata_d  = addr_lo_q;
                        d_in_d      = io_rdata;
                        ready_d     = 1'b1;
                    end
                    PCW: begin
                        fsm_d      = WR_WAIT;
                        mem_addr_d = ADDR_WIDTH'({disp_hi_s, addr_lo_q});
                        ready_d    = 1'b1;
                    end
                    default: begin
                        fsm_d      = RD_REQ;
                        mem_addr_d = ADDR_WIDTH'({disp_hi_s, addr_lo_q});
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        ready_d    = 1'b0;
                    end
                endcase
            end
        end else begin
            io_strobe_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            addr_lo_q   <= 8'h00;
            addr_hi_q   <= 6'h00;
            cyc_q       <= PCI;
            int_cyc_q   <= 1'b0;
            pend_t1_q   <= 1'b0;
            pend_t2_q   <= 1'b0;
            d_in_q      <= 8'h00;
            ready_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= 8'h00;
            io_strobe_q <= 1'b0;
            io_port_q   <= 5'd0;
            io_wdata_q  <= 8'h00;
        end else begin
            fsm_q       <= fsm_d;
            addr_lo_q   <= addr_lo_d;
            addr_hi_q   <= addr_hi_d;
            cyc_q       <= cyc_d;
            int_cyc_q   <= int_cyc_d;
            pend_t1_q   <= pend_t1_d;
            pend_t2_q   <= pend_t2_d;
            d_in_q      <= d_in_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            io_strobe_q <= io_strobe_d;
            io_port_q   <= io_port_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

    assign D_in      = d_in_q;
    assign READY     = ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign io_strobe = io_strobe_q;
    assign io_port   = io_port_q;
    assign io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_i8008_mem_if.sv
// Directed bench for i8008_mem_if: fetch, write with deferred read, interrupt
// fetch, I/O cycle, reset mid-request and top-of-address read.
module tb_i8008_mem_if;
    import i8008_mem_if_pkg::*;

    logic        clk;
    logic        rst;
    state_t      state;
    logic        Sync;
    logic [7:0]  D_out;
    logic [7:0]  D_in;
    logic        READY;
    logic [7:0]  int_instr;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        io_strobe;
    logic [4:0]  io_port;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;

    int total = 0;
    int bad   = 0;

    i8008_mem_if #(.ADDR_WIDTH(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .Sync      (Sync),
        .D_out     (D_out),
        .D_in      (D_in),
        .READY     (READY),
        .int_instr (int_instr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .io_strobe (io_strobe),
        .io_port   (io_port),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one T-state and let the DUT sample it; outputs are checked #1 after the edge.
    task automatic step(input state_t s, input logic [7:0] d);
        state = s;
        D_out = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        state     = STOPPED;
        Sync      = 1'b0;
        D_out     = 8'h00;
        int_instr = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        io_rdata  = 8'h9E;
        step(STOPPED, 8'h00);
        step(STOPPED, 8'h00);

        // Reset state
        chk("rst_d_in", D_in, 8'h00);
        chk("rst_ready", READY, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 14'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_io_strobe", io_strobe, 1'b0);
        chk("rst_io_port", io_port, 5'd0);
        chk("rst_io_wdata", io_wdata, 8'h00);
        rst = 1'b0;

        // PCI fetch from 0x1234, ack three cycles after T2
        step(T1, 8'h34);
        chk("pci_no_req_t1", mem_req, 1'b0);
        step(T2, 8'h12);
        chk("pci_req", mem_req, 1'b1);
        chk("pci_we", mem_we, 1'b0);
        chk("pci_addr", mem_addr, 14'h1234);
        chk("pci_ready_lo", READY, 1'b0);
        step(T_WAIT, 8'h00);
        chk("pci_req_held", mem_req, 1'b1);
        step(T_WAIT, 8'h00);
        chk("pci_addr_held", mem_addr, 14'h1234);
        mem_ack   = 1'b1;
        mem_rdata = 8'hC0;
        step(T_WAIT, 8'h00);
        mem_ack   = 1'b0;
        chk("pci_d_in", D_in, 8'hC0);
        chk("pci_ready", READY, 1'b1);
        chk("pci_req_drop", mem_req, 1'b0);
        step(T_WAIT, 8'h00);
        chk("pci_ready_hold", READY, 1'b1);
        step(T3, 8'h00);
        chk("pci_ready_fall", READY, 1'b0);
        chk("pci_d_in_keep", D_in, 8'hC0);
        step(T4, 8'h00);
        step(T5, 8'h00);

        // PCW to 0x0510 with data 0xAA, then a PCR to 0x0020 deferred behind it
        step(T1, 8'h10);
        step(T2, 8'hC5);
        chk("pcw_ready_wait", READY, 1'b1);
        chk("pcw_no_req", mem_req, 1'b0);
        chk("pcw_addr", mem_addr, 14'h0510);
        step(T3, 8'hAA);
        chk("pcw_req", mem_req, 1'b1);
        chk("pcw_we", mem_we, 1'b1);
        chk("pcw_wdata", mem_wdata, 8'hAA);
        chk("pcw_ready_lo", READY, 1'b0);
        step(T1, 8'h20);
        chk("pcw_addr_stable", mem_addr, 14'h0510);
        step(T2, 8'h80);
        chk("defer_ready_lo", READY, 1'b0);
        chk("defer_still_wr", mem_we, 1'b1);
        chk("defer_addr_stable", mem_addr, 14'h0510);
        step(T_WAIT, 8'h00);
        chk("defer_ready_lo2", READY, 1'b0);
        mem_ack = 1'b1;
        step(T_WAIT, 8'h00);
        mem_ack = 1'b0;
        chk("defer_rd_req", mem_req, 1'b1);
        chk("defer_rd_we", mem_we, 1'b0);
        chk("defer_rd_addr", mem_addr, 14'h0020);
        chk("defer_ready_lo3", READY, 1'b0);
        step(T_WAIT, 8'h00);
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        step(T_WAIT, 8'h00);
        mem_ack   = 1'b0;
        chk("defer_d_in", D_in, 8'h5A);
        chk("defer_ready", READY, 1'b1);
        step(T3, 8'h00);
        chk("defer_ready_fall", READY, 1'b0);

        // Interrupt fetch: jammed RST 0 style opcode, no memory traffic
        int_instr = 8'b00_000_101;
        step(T1I, 8'h00);
        chk("t1i_no_req_a", mem_req, 1'b0);
        step(T2, 8'h00);
        chk("t1i_no_req_b", mem_req, 1'b0);
        chk("t1i_d_in", D_in, 8'h05);
        chk("t1i_ready", READY, 1'b1);
        step(T3, 8'h00);
        chk("t1i_ready_fall", READY, 1'b0);
        chk("t1i_no_req_c", mem_req, 1'b0);

        // PCC: port 5, output data 0x77, input data from io_rdata
        step(T1, 8'h77);
        step(T2, 8'h4A);
        chk("pcc_strobe", io_strobe, 1'b1);
        chk("pcc_port", io_port, 5'd5);
        chk("pcc_wdata", io_wdata, 8'h77);
        chk("pcc_d_in", D_in, 8'h9E);
        chk("pcc_ready", READY, 1'b1);
        chk("pcc_no_req", mem_req, 1'b0);
        step(T_WAIT, 8'h00);
        chk("pcc_strobe_1cyc", io_strobe, 1'b0);
        step(T3, 8'h00);
        chk("pcc_ready_fall", READY, 1'b0);

        // Reset while a read is outstanding; the late ack is dropped
        step(T1, 8'h00);
        step(T2, 8'h00);
        chk("rstreq_req", mem_req, 1'b1);
        rst = 1'b1;
        step(T_WAIT, 8'h00);
        rst = 1'b0;
        chk("rstreq_req_drop", mem_req, 1'b0);
        chk("rstreq_ready", READY, 1'b0);
        chk("rstreq_d_in", D_in, 8'h00);
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
        step(T_WAIT, 8'h00);
        mem_ack   = 1'b0;
        chk("late_ack_req", mem_req, 1'b0);
        chk("late_ack_ready", READY, 1'b0);
        chk("late_ack_d_in", D_in, 8'h00);

        // PCR at 0x3FFF, ack in the first request cycle (minimum gap)
        step(T1, 8'hFF);
        step(T2, 8'hBF);
        chk("top_addr", mem_addr, 14'h3FFF);
        chk("top_req", mem_req, 1'b1);
        mem_ack   = 1'b1;
        mem_rdata = 8'h11;
        step(T_WAIT, 8'h00);
        mem_ack   = 1'b0;
        chk("top_ready_gap2", READY, 1'b1);
        chk("top_d_in", D_in, 8'h11);
        step(T3, 8'h00);
        chk("top_ready_fall", READY, 1'b0);

        // STOPPED: nothing captured, stray ack ignored
        step(STOPPED, 8'h40);
        chk("stop_no_req", mem_req, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        step(STOPPED, 8'h40);
        mem_ack   = 1'b0;
        chk("stop_ack_d_in", D_in, 8'h11);
        chk("stop_ack_ready", READY, 1'b0);
        step(STOPPED, 8'h80);
        chk("stop_no_req2", mem_req, 1'b0);
        chk("stop_addr_keep", mem_addr, 14'h3FFF);
        chk("stop_no_strobe", io_strobe, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
